// File: rtl/make_ack_queue.sv
// make_ack_queue: buffered ack generator. Watches locally delivered flits and
// queues an acknowledgement for every data flit addressed to this node, then
// emits the acks (src/dst swapped, is_ack set) over a valid/ready handshake.

package types;
  localparam int ID_W = 4;

  typedef struct packed {
    logic            is_ack;
    logic [ID_W-1:0] src_id;
    logic [ID_W-1:0] dst_id;
  } hdr_t;

  typedef struct packed {
    hdr_t        header;
    logic [31:0] payload;
  } flit_t;
endpackage

module make_ack_queue #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [types::ID_W-1:0] this_id,
  input  logic                  ack_en,
  input  logic                  in_valid,
  input  types::flit_t          in_flit,
  output logic                  in_ready,
  output logic                  out_valid,
  output types::flit_t          out_flit,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  ack_count,
  output logic                  full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = types::ID_W;

  // Queue storage: only the two IDs are kept; the ack is rebuilt at the head.
  logic [IW-1:0] r_src [DEPTH];
  logic [IW-1:0] r_dst [DEPTH];

  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [PW:0]          r_count;
  logic [CNT_WIDTH-1:0] r_ack_count;

  logic w_needs;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // Payload never influences the ack; fold it into a sink net.
  assign w_unused = ^in_flit.payload;

  assign w_needs = ack_en && !in_flit.header.is_ack && (in_flit.header.dst_id == this_id);
  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // No bypass: a full queue refuses needs-ack flits even if the head pops now.
  assign in_ready  = !w_full || !w_needs;
  assign w_push    = in_valid && in_ready && w_needs;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign full      = w_full;
  assign ack_count = r_ack_count;

  // Build the ack from the head entry; all-zero while the queue is empty.
  always_comb begin
    out_flit = '0;
    if (!w_empty) begin
      out_flit.header.is_ack = 1'b1;
      out_flit.header.dst_id = r_src[r_rptr];
      out_flit.header.src_id = r_dst[r_rptr];
    end
  end

  // Entry write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_src[r_wptr] <= in_flit.header.src_id;
      r_dst[r_wptr] <= in_flit.header.dst_id;
    end
  end

  // Pointers, occupancy and ack counter; power-of-two depth wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ack_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr      <= r_wptr + PW'(1);
        r_ack_count <= r_ack_count + CNT_WIDTH'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (PW+1)'(1);
    end
  end
endmodule
